// File: rtl/ov7670_pixel_stream_if.sv
// ov7670_pixel_stream_if: OV7670 byte bus in, coordinate-tagged pixel stream out
// OV7670_OBJECT_THRESH_EN adds the object threshold inputs thresh_r/thresh_gb
interface ov7670_pixel_stream_if #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10
);
  logic cam_vsync;
  logic cam_href;
  logic [7:0] cam_data;
  logic frame_valid;
  logic pixel_valid;
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  logic [15:0] pixel;
  logic object_pixel;
  logic line_err;
`ifdef OV7670_OBJECT_THRESH_EN
  logic [4:0] thresh_r;
  logic [5:0] thresh_gb;
  modport master(
    output cam_vsync, cam_href, cam_data, thresh_r, thresh_gb,
    input frame_valid, pixel_valid, x, y, pixel, object_pixel, line_err
  );
  modport slave(
    input cam_vsync, cam_href, cam_data, thresh_r, thresh_gb,
    output frame_valid, pixel_valid, x, y, pixel, object_pixel, line_err
  );
`else
  modport master(
    output cam_vsync, cam_href, cam_data,
    input frame_valid, pixel_valid, x, y, pixel, object_pixel, line_err
  );
  modport slave(
    input cam_vsync, cam_href, cam_data,
    output frame_valid, pixel_valid, x, y, pixel, object_pixel, line_err
  );
`endif
endinterface

// File: rtl/ov7670_pixel_stream.sv
// ov7670_pixel_stream: pairs OV7670 RGB565 bytes into x/y-tagged pixels framed by vsync
// OV7670_OBJECT_THRESH_EN enables the threshold-based object_pixel flag
module ov7670_pixel_stream #(
  parameter int X_WIDTH  = 10,
  parameter int Y_WIDTH  = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input logic clk,
  input logic rst,
  ov7670_pixel_stream_if.slave bus
);
  typedef enum logic [1:0] {UNLOCKED, BLANK, ACTIVE} state_t;
  state_t state;
  logic vsync_q, vsync_qq, href_q, href_qq, phase_lo, line_px;
  logic [7:0] data_q, hi_byte;
  logic [X_WIDTH-1:0] xc;
  logic [Y_WIDTH-1:0] yc;
  logic [15:0] asm_px;
  logic obj, vs_rise, vs_fall, in_range;
  assign asm_px   = {hi_byte, data_q};
  assign vs_rise  = vsync_q & ~vsync_qq;
  assign vs_fall  = ~vsync_q & vsync_qq;
  assign in_range = (int'(xc) < H_ACTIVE) && (int'(yc) < V_ACTIVE);
`ifdef OV7670_OBJECT_THRESH_EN
  assign obj = (asm_px[15:11] >= bus.thresh_r) && (asm_px[10:5] < bus.thresh_gb) &&
               ({asm_px[4:0], 1'b0} < bus.thresh_gb);
`else
  assign obj = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNLOCKED;
      vsync_q <= 1'b0;
      vsync_qq <= 1'b0;
      href_q <= 1'b0;
      href_qq <= 1'b0;
      data_q <= '0;
      hi_byte <= '0;
      phase_lo <= 1'b0;
      line_px <= 1'b0;
      xc <= '0;
      yc <= '0;
      bus.frame_valid <= 1'b0;
      bus.pixel_valid <= 1'b0;
      bus.x <= '0;
      bus.y <= '0;
      bus.pixel <= '0;
      bus.object_pixel <= 1'b0;
      bus.line_err <= 1'b0;
    end else begin
      vsync_q <= bus.cam_vsync;
      vsync_qq <= vsync_q;
      href_q <= bus.cam_href;
      href_qq <= href_q;
      data_q <= bus.cam_data;
      bus.pixel_valid <= 1'b0;
      case (state)
        UNLOCKED: if (vs_rise) state <= BLANK;
        BLANK: if (vs_fall) begin
          state <= ACTIVE;
          bus.frame_valid <= 1'b1;
          bus.line_err <= 1'b0;
          phase_lo <= 1'b0;
          line_px <= 1'b0;
          xc <= '0;
          yc <= '0;
        end
        ACTIVE: if (vs_rise) begin
          // any byte arriving alongside vsync is dropped, so the frame ends with no strobe pending
          state <= BLANK;
          bus.frame_valid <= 1'b0;
          phase_lo <= 1'b0;
          line_px <= 1'b0;
          xc <= '0;
          if (phase_lo) bus.line_err <= 1'b1;
        end else if (href_q) begin
          phase_lo <= ~phase_lo;
          if (!phase_lo) hi_byte <= data_q;
          else if (in_range) begin
            bus.pixel_valid <= 1'b1;
            bus.pixel <= asm_px;
            bus.object_pixel <= obj;
            bus.x <= xc;
            bus.y <= yc;
            xc <= xc + 1'b1;
            line_px <= 1'b1;
          end else bus.line_err <= 1'b1;
        end else if (href_qq) begin
          phase_lo <= 1'b0;
          line_px <= 1'b0;
          xc <= '0;
          bus.x <= '0;
          if (phase_lo) bus.line_err <= 1'b1;
          if (line_px) yc <= yc + 1'b1;
        end
        default: state <= UNLOCKED;
      endcase
    end
  end
endmodule

// File: tb/tb_ov7670_pixel_stream.sv
// tb_ov7670_pixel_stream: randomized frames checked against a line-level reference model via scoreboard
`timescale 1ns/1ps
module tb_ov7670_pixel_stream;
  localparam int XW = 10, YW = 10, HA = 4, VA = 2;
`ifdef OV7670_OBJECT_THRESH_EN
  localparam bit OBJ_EN = 1'b1;
`else
  localparam bit OBJ_EN = 1'b0;
`endif
  typedef struct packed {logic [XW-1:0] x; logic [YW-1:0] y; logic [15:0] px; logic obj;} exp_t;
  typedef logic [7:0] bytes_t[$];
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0, cyc = 0, v_cyc = 0, fall_cyc = -1, ly = 0;
  bit q_empty_at_fall = 1'b0, fv_prev = 1'b0, pv_prev = 1'b0, fv_seen = 1'b0, ferr = 1'b0;
  exp_t exp_q[$];
  int lens[$];
  logic [4:0] tr = '0;
  logic [5:0] tg = '0;
  ov7670_pixel_stream_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) bus();
  ov7670_pixel_stream #(.X_WIDTH(XW), .Y_WIDTH(YW), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`ifdef OV7670_OBJECT_THRESH_EN
  assign bus.thresh_r = tr;
  assign bus.thresh_gb = tg;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic obj_of(input logic [15:0] p);
    return OBJ_EN && (p[15:11] >= tr) && (p[10:5] < tg) && ({p[4:0], 1'b0} < tg);
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      fv_prev = 1'b0;
      pv_prev = 1'b0;
    end else begin
      if (bus.pixel_valid) begin
        chk("pv_in_frame", 32'(bus.frame_valid), 32'd1);
        chk("pv_spacing", 32'(pv_prev), 32'd0);
        chk("pv_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("x", 32'(bus.x), 32'(e.x));
          chk("y", 32'(bus.y), 32'(e.y));
          chk("pixel", 32'(bus.pixel), 32'(e.px));
          chk("object_pixel", 32'(bus.object_pixel), 32'(e.obj));
        end
      end
      if (fv_prev && !bus.frame_valid) begin
        fall_cyc = cyc;
        q_empty_at_fall = (exp_q.size() == 0);
      end
      if (bus.frame_valid) fv_seen = 1'b1;
      fv_prev = bus.frame_valid;
      pv_prev = bus.pixel_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bytes_t gen(input int n, input int pat);
    bytes_t b;
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      p = (pat == 1 || (pat == 2 && (i / 2) % 2 == 0)) ? 16'hF800 :
          (pat == 2) ? 16'h07E0 : 16'($urandom);
      b.push_back((i % 2) ? p[7:0] : p[15:8]);
    end
    return b;
  endfunction

  // A line yields floor(n/2) pixels; only the first HA of them, and only on the first VA productive lines
  task automatic model_line(input bytes_t b);
    int em = 0;
    exp_t e;
    if (b.size() % 2 != 0) ferr = 1'b1;
    for (int i = 0; i < b.size() / 2; i++) begin
      if (i < HA && ly < VA) begin
        e.x = XW'(i);
        e.y = YW'(ly);
        e.px = {b[2*i], b[2*i+1]};
        e.obj = obj_of(e.px);
        exp_q.push_back(e);
        em++;
      end else ferr = 1'b1;
    end
    if (em > 0) ly++;
  endtask

  task automatic drive_line(input bytes_t b, input bit vs_end);
    foreach (b[i]) begin
      tick();
      bus.cam_href = 1'b1;
      bus.cam_data = b[i];
    end
    if (vs_end) begin
      tick();
      bus.cam_vsync = 1'b1;
      v_cyc = cyc;
      bus.cam_data = 8'($urandom);
    end
    tick();
    bus.cam_href = 1'b0;
    repeat ($urandom_range(4, 1)) tick();
  endtask

  task automatic run_frame(input int fl[$], input int pat, input bit vs_href);
    bytes_t b;
    tick();
    bus.cam_vsync = 1'b0;
    repeat (3) tick();
    chk("fv_start", 32'(bus.frame_valid), 32'd1);
    chk("err_clear", 32'(bus.line_err), 32'd0);
    ly = 0;
    ferr = 1'b0;
    fall_cyc = -1;
    foreach (fl[l]) begin
      b = gen(fl[l], pat);
      model_line(b);
      drive_line(b, vs_href && l == fl.size() - 1);
    end
    if (!vs_href) begin
      tick();
      bus.cam_vsync = 1'b1;
      v_cyc = cyc;
    end
    repeat (6) tick();
    chk("fv_fall_latency", 32'(fall_cyc - v_cyc), 32'd2);
    chk("flushed_at_fall", 32'(q_empty_at_fall), 32'd1);
    chk("line_err", 32'(bus.line_err), 32'(ferr));
  endtask

  initial begin
    bus.cam_vsync = 1'b0;
    bus.cam_href = 1'b0;
    bus.cam_data = '0;
    repeat (3) tick();
    chk("rst_fv", 32'(bus.frame_valid), 32'd0);
    chk("rst_pv", 32'(bus.pixel_valid), 32'd0);
    chk("rst_err", 32'(bus.line_err), 32'd0);
    chk("rst_x", 32'(bus.x), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_pixel", 32'(bus.pixel), 32'd0);
    chk("rst_obj", 32'(bus.object_pixel), 32'd0);
    rst = 1'b0;
    tick();
    bus.cam_vsync = 1'b1;
    repeat (3) tick();
    lens = '{8, 8};
    run_frame(lens, 1, 1'b0);
    lens = '{7};
    run_frame(lens, 0, 1'b0);
    lens = '{8};
    run_frame(lens, 0, 1'b0);
    lens = '{12};
    run_frame(lens, 1, 1'b0);
    lens = '{8, 8, 8};
    run_frame(lens, 0, 1'b0);
    lens = '{5};
    run_frame(lens, 0, 1'b1);
    tr = 5'd16;
    tg = 6'd8;
    lens = '{8};
    run_frame(lens, 2, 1'b0);
    repeat (8) begin
      tr = 5'($urandom);
      tg = 6'($urandom);
      lens.delete();
      repeat ($urandom_range(3, 1)) lens.push_back($urandom_range(11, 1));
      run_frame(lens, 0, 1'($urandom_range(1, 0)));
    end
    rst = 1'b1;
    tick();
    chk("rst2_fv", 32'(bus.frame_valid), 32'd0);
    chk("rst2_err", 32'(bus.line_err), 32'd0);
    bus.cam_vsync = 1'b0;
    drive_line(gen(8, 0), 1'b0);
    rst = 1'b0;
    fv_seen = 1'b0;
    repeat (3) drive_line(gen(6, 0), 1'b0);
    chk("no_fv_before_vsync", 32'(fv_seen), 32'd0);
    tick();
    bus.cam_vsync = 1'b1;
    repeat (3) tick();
    lens = '{8, 4};
    run_frame(lens, 0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ov7670_pixel_stream.md
Name: ov7670_pixel_stream

Overview:
- Front end of the capture path: turns raw OV7670 VSYNC/HREF/8-bit byte bus into the coordinate-tagged pixel stream that downstream analysis blocks consume: frame_valid, pixel_valid, x, y, pixel, object_pixel.
- Pairs RGB565 bytes into pixels, generates x/y counters and frames the stream so frame_valid falls only after the last pixel of a frame.

Parameters:
- X_WIDTH, 10, width of x coordinate.
- Y_WIDTH, 10, width of y coordinate.
- H_ACTIVE, 640, max pixels accepted per line.
- V_ACTIVE, 480, max lines accepted per frame.

Ports:
- clk  input  1  camera pixel clock domain (PCLK-derived), all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- cam_vsync  input  1  high during vertical blanking.
- cam_href  input  1  high while line bytes are valid.
- cam_data  input  8  camera byte bus, sampled every clk while cam_href high.
- frame_valid  output  1  high for the whole active frame.
- pixel_valid  output  1  one-cycle strobe per completed pixel.
- x  output  X_WIDTH  column of current pixel, valid with pixel_valid.
- y  output  Y_WIDTH  row of current pixel, valid with pixel_valid.
- pixel  output  16  RGB565 pixel, valid with pixel_valid.
- object_pixel  output  1  object flag, valid with pixel_valid.
- line_err  output  1  sticky until next frame start: odd byte count or overflow seen.

Behaviour:
- Inputs registered once (cam_*_q); all decisions use registered copies.
- Reset: all outputs 0, byte phase = HIGH, x=y=0, state = UNLOCKED.
- States: UNLOCKED -> (vsync rising edge) BLANK -> (vsync falling edge) ACTIVE -> (vsync rising edge) BLANK. Rst mid-frame returns to UNLOCKED: no frame_valid until a full vsync pulse seen, so no partial frame is ever emitted.
- frame_valid: 1 in ACTIVE. On vsync rise, deasserts one cycle after the final pixel_valid strobe could occur (pipeline flushed first), so consumers latch complete sums.
- Byte pairing: first byte in a line is pixel[15:8], second pixel[7:0]; pixel_valid asserted the cycle after the second byte is registered (latency 2 clk from the second byte on cam_data).
- x: value of pixel being emitted; increments after each pixel_valid; cleared on href falling edge.
- y: increments on href falling edge only if the line produced >=1 pixel; cleared on entry to ACTIVE.
- href falls with odd byte count: partial byte discarded, byte phase reset to HIGH, line_err set.
- Pixel with x >= H_ACTIVE or line with y >= V_ACTIVE: suppressed (no pixel_valid, counters saturate), line_err set.
- line_err cleared on entry to ACTIVE.
- vsync rise while href high: line terminated as if href fell (same odd-byte rule), then frame ends.
- pixel_valid never asserted outside ACTIVE; at most one per two clk.
- object_pixel = 0 unless OBJECT_THRESH_EN compiled in.

Optional Feature:
- Macro OV7670_OBJECT_THRESH_EN.
- Defined: adds inputs thresh_r (5 bits) and thresh_gb (6 bits). object_pixel = (R >= thresh_r) && (G < thresh_gb) && ({B,1'b0} < thresh_gb), where R = pixel[15:11], G = pixel[10:5], B = pixel[4:0]. Computed combinationally from the assembled pixel, registered with pixel_valid, same latency.
- Undefined: ports absent, object_pixel constant 0.

Test Plan:
- Reset, then vsync pulse, then 2 lines x 4 pixels (bytes 0xF8,0x00 repeating) -> 8 pixel_valid strobes, x 0..3, y 0..1, pixel=0xF800, frame_valid falls after the 8th strobe, line_err=0.
- Release reset mid-frame (vsync low, href toggling) -> no frame_valid or pixel_valid until after the next full vsync pulse.
- Line with 7 bytes -> 3 pixels, line_err=1; next frame start clears line_err.
- H_ACTIVE=4, line of 6 pixels -> only x 0..3 emitted, line_err=1; V_ACTIVE=2 with 3 lines -> third line produces no strobes.
- vsync rises while href high after 5 bytes -> 2 pixels emitted, line_err=1, frame_valid falls the cycle after the flush.
- OV7670_OBJECT_THRESH_EN, thresh_r=16, thresh_gb=8, pixels 0xF800 and 0x07E0 -> object_pixel 1 then 0.
